// File: rtl/led_mode_ctrl.sv
// LED mode sequencer driven by a debounced key: short presses step OFF->ON->SLOW->FAST,
// a long press forces OFF and lights led2 while held. All outputs are registered.
module led_mode_ctrl #(
    parameter int LONG_CYC  = 50_000_000,
    parameter int SLOW_HALF = 25_000_000,
    parameter int FAST_HALF = 5_000_000,
    parameter int CNT_W     = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       led1,
    output logic       led2,
    output logic [1:0] mode,
    output logic       mode_chg,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [CNT_W-1:0] r_blink_cnt, w_blink_nxt;
    logic [CNT_W-1:0] w_half_last;
    logic [1:0]       r_mode, w_mode_nxt;
    logic             r_led1, w_led1_nxt;
    logic             r_led2, w_led2_nxt;
    logic             r_mode_chg, w_chg_nxt;
    logic             w_press, w_release;

    // key_flag marks an edge; key_state tells which one (0 = now pressed).
    assign w_press   = key_flag & ~key_state;
    assign w_release = key_flag & key_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
            r_mode      <= 2'd0;
            r_led1      <= 1'b0;
            r_led2      <= 1'b0;
            r_mode_chg  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_blink_cnt <= w_blink_nxt;
            r_mode      <= w_mode_nxt;
            r_led1      <= w_led1_nxt;
            r_led2      <= w_led2_nxt;
            r_mode_chg  <= w_chg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_mode_nxt  = r_mode;
        w_led2_nxt  = r_led2;
        w_chg_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt = ST_PRESSED;
                    w_hold_nxt  = '0;
                end
            end
            ST_PRESSED: begin
                w_hold_nxt = r_hold_cnt + CNT_W'(1);
                // A release on the threshold cycle still counts as a short press.
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_mode_nxt  = r_mode + 2'd1;
                    w_chg_nxt   = 1'b1;
                end else if (r_hold_cnt == LONG_LAST) begin
                    w_state_nxt = ST_LONG;
                    w_mode_nxt  = 2'd0;
                    w_chg_nxt   = 1'b1;
                    w_led2_nxt  = 1'b1;
                end
            end
            ST_LONG: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_led2_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_blink_nxt = r_blink_cnt;
        w_led1_nxt  = r_led1;
        w_half_last = '0;
        case (r_mode)
            2'd2:    w_half_last = SLOW_LAST;
            2'd3:    w_half_last = FAST_LAST;
            default: w_half_last = '0;
        endcase
        // A mode change restarts the blink phase and overrides any pending toggle.
        if (w_chg_nxt) begin
            w_blink_nxt = '0;
            w_led1_nxt  = (w_mode_nxt != 2'd0);
        end else if (r_mode == 2'd0) begin
            w_blink_nxt = '0;
            w_led1_nxt  = 1'b0;
        end else if (r_mode == 2'd1) begin
            w_blink_nxt = '0;
            w_led1_nxt  = 1'b1;
        end else if (r_blink_cnt == w_half_last) begin
            w_blink_nxt = '0;
            w_led1_nxt  = ~r_led1;
        end else begin
            w_blink_nxt = r_blink_cnt + CNT_W'(1);
        end
    end

    assign led1      = r_led1;
    assign led2      = r_led2;
    assign mode      = r_mode;
    assign mode_chg  = r_mode_chg;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed and random key activity compared every cycle
// against a time-based reference model of the mode/LED rules.
module tb_led_mode_ctrl;

    localparam int LONG_CYC  = 20;
    localparam int SLOW_HALF = 8;
    localparam int FAST_HALF = 3;
    localparam int CNT_W     = 8;

    logic       clk;
    logic       rst;
    logic       key_flag;
    logic       key_state;
    logic       led1;
    logic       led2;
    logic [1:0] mode;
    logic       mode_chg;
    logic [1:0] dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    // reference model state
    logic [1:0] m_mode;
    logic       m_chg;
    logic       m_led2;
    bit         m_down;
    bit         m_long;
    int         m_age;
    int         m_t;

    led_mode_ctrl #(
        .LONG_CYC (LONG_CYC),
        .SLOW_HALF(SLOW_HALF),
        .FAST_HALF(FAST_HALF),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_flag (key_flag),
        .key_state(key_state),
        .led1     (led1),
        .led2     (led2),
        .mode     (mode),
        .mode_chg (mode_chg),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 2'd0;
        m_chg  = 1'b0;
        m_led2 = 1'b0;
        m_down = 1'b0;
        m_long = 1'b0;
        m_age  = 0;
        m_t    = 0;
    endtask

    // m_age = clock edges since the press edge; m_t = edges since the last mode change.
    task automatic model_edge(input bit prs, input bit rel);
        m_chg = 1'b0;
        if (m_down) begin
            m_age++;
            if (rel) begin
                m_down = 1'b0;
                m_mode = m_mode + 2'd1;
                m_chg  = 1'b1;
            end else if (m_age == LONG_CYC) begin
                m_down = 1'b0;
                m_long = 1'b1;
                m_mode = 2'd0;
                m_chg  = 1'b1;
                m_led2 = 1'b1;
            end
        end else if (m_long) begin
            if (rel) begin
                m_long = 1'b0;
                m_led2 = 1'b0;
            end
        end else if (prs) begin
            m_down = 1'b1;
            m_age  = 0;
        end
        if (m_chg) m_t = 0;
        else       m_t++;
    endtask

    function automatic logic exp_led1();
        case (m_mode)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            2'd2:    return ((m_t / SLOW_HALF) % 2) == 0;
            default: return ((m_t / FAST_HALF) % 2) == 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("mode",     {6'd0, mode},     {6'd0, m_mode});
        check("mode_chg", {7'd0, mode_chg}, {7'd0, m_chg});
        check("led1",     {7'd0, led1},     {7'd0, exp_led1()});
        check("led2",     {7'd0, led2},     {7'd0, m_led2});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(key_flag & ~key_state, key_flag & key_state);
        #1;
        check_all();
        key_flag = 1'b0;
    endtask

    task automatic pulse(input logic level);
        key_state = level;
        key_flag  = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // hold = clock edges from the press pulse to the release pulse
    task automatic press_for(input int hold);
        pulse(1'b0);
        idle(hold - 1);
        pulse(1'b1);
    endtask

    task automatic goto_mode(input logic [1:0] target);
        for (int i = 0; i < 4 && m_mode != target; i++) begin
            press_for(5);
            idle(2);
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_flag  = 1'b0;
        key_state = 1'b1;
        model_reset();
        #2;
        check_all();
        idle(2);
        rst = 1'b0;
        idle(2);

        // four short presses: mode 1,2,3,0
        for (int i = 0; i < 4; i++) begin
            press_for(5);
            idle(3);
        end

        // free-running SLOW then FAST blink
        goto_mode(2'd2);
        idle(40);
        press_for(4);
        idle(20);

        // long press from FAST, then release leaves mode at 0
        goto_mode(2'd3);
        press_for(30);
        idle(5);

        // release on the exact threshold edge is a short press
        press_for(LONG_CYC);
        idle(5);

        // long press while already OFF still pulses mode_chg
        goto_mode(2'd0);
        press_for(25);
        idle(3);

        // reset during a held press; the later release must be ignored
        goto_mode(2'd2);
        pulse(1'b0);
        idle(4);
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        idle(2);
        rst = 1'b0;
        idle(2);
        pulse(1'b1);
        idle(3);

        // short press released on the SLOW blink wrap edge
        goto_mode(2'd2);
        idle(3);
        pulse(1'b0);
        begin
            int waited;
            waited = 0;
            while ((m_t % SLOW_HALF) != SLOW_HALF - 1 && waited < 64) begin
                tick();
                waited++;
            end
            n_vec++;
            if ((m_t % SLOW_HALF) != SLOW_HALF - 1) begin
                n_fail++;
                $display("FAIL wrap_wait observed=timeout required=wrap_phase");
            end
        end
        pulse(1'b1);
        idle(6);

        // random key activity with spurious edges
        for (int k = 0; k < 30; k++) begin
            int gap;
            int hold;
            gap  = $urandom_range(0, 20);
            hold = $urandom_range(1, 28);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 9) == 0) pulse(1'b1);
                else tick();
            end
            pulse(1'b0);
            for (int h = 1; h < hold; h++) begin
                if ($urandom_range(0, 7) == 0) pulse(1'b0);
                else tick();
            end
            pulse(1'b1);
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
